// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one external combinational 32-bit ALU between four
//                requesters. Round-robin arbitration picks one requester. Its
//                operands are registered and driven to the ALU. The ALU result
//                and flags are captured one cycle later and returned to that
//                requester over its own valid/ready response channel. Only one
//                operation is in flight at a time.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional build macro:
//    ALU_ARB_STATS_EN - adds the grant_cnt output and one saturating
//                       per-user handshake counter (CNT_WIDTH bits each).
// ----------------------------------------------------------------------------
//  Ports:
//    clk           in   rising-edge clock
//    resetn        in   asynchronous active-low reset
//    req_valid     in   [NUM_USERS]  per-user request valid
//    req_ready     out  [NUM_USERS]  per-user request accept (one-hot or 0)
//    req_a/req_b   in   [NUM_USERS*DATA_WIDTH] operands, user i at [i*DW +: DW]
//    req_op        in   [NUM_USERS*3] ALU opcode, user i at [i*3 +: 3]
//    resp_valid    out  [NUM_USERS]  per-user response valid (one-hot or 0)
//    resp_ready    in   [NUM_USERS]  per-user response accept
//    resp_result   out  [DATA_WIDTH] captured ALU result
//    resp_flags    out  [3]          {Overflow, CarryOut, Zero}
//    alu_a/alu_b   out  [DATA_WIDTH] registered operands to the ALU
//    alu_op        out  [3]          registered opcode to the ALU
//    alu_result    in   [DATA_WIDTH] ALU result
//    alu_overflow/alu_carryout/alu_zero  in  ALU flags
//    busy          out  high while an operation is in flight
//    grant_cnt     out  [NUM_USERS*CNT_WIDTH] (ALU_ARB_STATS_EN only)
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_USERS  = 4
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                            clk,
    input  logic                            resetn,
    // request channels
    input  logic [NUM_USERS-1:0]            req_valid,
    output logic [NUM_USERS-1:0]            req_ready,
    input  logic [NUM_USERS*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_USERS*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_USERS*3-1:0]          req_op,
    // response channels
    output logic [NUM_USERS-1:0]            resp_valid,
    input  logic [NUM_USERS-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]           resp_result,
    output logic [2:0]                      resp_flags,
    // external ALU
    output logic [DATA_WIDTH-1:0]           alu_a,
    output logic [DATA_WIDTH-1:0]           alu_b,
    output logic [2:0]                      alu_op,
    input  logic [DATA_WIDTH-1:0]           alu_result,
    input  logic                            alu_overflow,
    input  logic                            alu_carryout,
    input  logic                            alu_zero,
    // status
    output logic                            busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_USERS*CNT_WIDTH-1:0]  grant_cnt
`endif
);

    // The round-robin search below is written for exactly four users.
    localparam int c_IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [c_IDX_W-1:0]      r_rr_ptr;
    logic [c_IDX_W-1:0]      r_grant;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [2:0]              r_alu_op;
    logic [DATA_WIDTH-1:0]   r_resp_result;
    logic [2:0]              r_resp_flags;
    logic [NUM_USERS-1:0]    r_resp_valid;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [2*NUM_USERS-1:0]  w_valid_dbl;
    logic [NUM_USERS-1:0]    w_valid_rot;
    logic [c_IDX_W-1:0]      w_win_ofs;
    logic                    w_win_found;
    logic [c_IDX_W-1:0]      w_win_idx;
    logic [NUM_USERS-1:0]    w_win_onehot;
    logic [NUM_USERS-1:0]    w_req_ready;
    logic                    w_req_fire;
    logic                    w_resp_accept;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;
    logic [2:0]              w_sel_op;

    // Rotate the valid vector so that bit 0 is the user at r_rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_valid_dbl = {req_valid, req_valid};
    assign w_valid_rot = w_valid_dbl[r_rr_ptr +: NUM_USERS];

    always_comb begin
        w_win_found = 1'b1;
        w_win_ofs   = 2'd0;
        casez (w_valid_rot)
            4'b???1: w_win_ofs = 2'd0;
            4'b??10: w_win_ofs = 2'd1;
            4'b?100: w_win_ofs = 2'd2;
            4'b1000: w_win_ofs = 2'd3;
            default: w_win_found = 1'b0;
        endcase
    end

    // Two-bit addition wraps modulo four, undoing the rotation.
    assign w_win_idx    = r_rr_ptr + w_win_ofs;
    assign w_win_onehot = {{(NUM_USERS-1){1'b0}}, 1'b1} << w_win_idx;

    // req_ready is gated by resetn directly so that it drops to zero the
    // moment reset asserts, even while a requester keeps req_valid high.
    assign w_req_ready = (resetn && (r_state == S_IDLE) && w_win_found)
                         ? w_win_onehot : '0;
    assign w_req_fire  = (r_state == S_IDLE) && w_win_found;

    // Only the granted user's resp_ready matters; other bits are ignored.
    assign w_resp_accept = resp_ready[r_grant];

    // Winner operand selection.
    assign w_sel_a  = req_a[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_b  = req_b[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_op = req_op[w_win_idx*3 +: 3];

    // ------------------------------------------------------------------
    // Control FSM with registered datapath outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
            r_resp_valid  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // ALU operand registers change only on an accepted
                    // request, so the ALU inputs stay quiet otherwise.
                    if (w_req_fire) begin
                        r_alu_a  <= w_sel_a;
                        r_alu_b  <= w_sel_b;
                        r_alu_op <= w_sel_op;
                        r_grant  <= w_win_idx;
                        r_state  <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    // The ALU has seen the registered operands for a full
                    // cycle; capture its combinational outputs.
                    r_resp_result <= alu_result;
                    r_resp_flags  <= {alu_overflow, alu_carryout, alu_zero};
                    r_resp_valid  <= {{(NUM_USERS-1){1'b0}}, 1'b1} << r_grant;
                    r_state       <= S_RESP;
                end

                S_RESP: begin
                    if (w_resp_accept) begin
                        r_resp_valid <= '0;
                        // Just-served user becomes lowest priority.
                        r_rr_ptr     <= r_grant + 2'd1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = w_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_flags  = r_resp_flags;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign busy        = (r_state != S_IDLE);

`ifdef ALU_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-user saturating request-handshake counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_grant_cnt
            logic [CNT_WIDTH-1:0] r_cnt;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_cnt <= '0;
                end else if (w_req_ready[gi] && req_valid[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter. Provides the
//                external ALU, drives directed and randomized requests, and
//                predicts grant order and results from a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic          clk = 1'b0;
    logic          resetn;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [11:0]   req_op;
    logic [3:0]    resp_valid;
    logic [3:0]    resp_ready;
    logic [31:0]   resp_result;
    logic [2:0]    resp_flags;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [2:0]    alu_op;
    logic [31:0]   alu_result;
    logic          alu_overflow;
    logic          alu_carryout;
    logic          alu_zero;
    logic          busy;
`ifdef ALU_ARB_STATS_EN
    logic [63:0]   grant_cnt;
`endif

    int            n_cmp = 0;
    int            n_mis = 0;

    // Behavioural model state
    int            ptr_m;
    logic [31:0]   ua [4];
    logic [31:0]   ub [4];
    logic [2:0]    uop [4];
    logic [31:0]   last_res;
    logic [2:0]    last_flags;
    logic [3:0]    last_rdy;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_flags   (resp_flags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .busy         (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    // ALU behaviour: returns {Overflow, CarryOut, Zero, Result}.
    // CarryOut on SUB signals an unsigned borrow (A < B).
    function automatic logic [34:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  op);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov;
        logic        co;
        ov = 1'b0;
        co = 1'b0;
        r  = '0;
        s  = '0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                r  = a - b;
                co = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    // The shared ALU instance the arbiter drives.
    always_comb begin
        {alu_overflow, alu_carryout, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_op);
    end

    // Round-robin reference: first valid user from ptr_m upward, modulo 4.
    function automatic int model_winner();
        for (int k = 0; k < 4; k++) begin
            if (req_valid[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_user(input int u, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op);
        ua[u]  = a;
        ub[u]  = b;
        uop[u] = op;
        req_a[u*32 +: 32] = a;
        req_b[u*32 +: 32] = b;
        req_op[u*3 +: 3]  = op;
        req_valid[u]      = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   req_ready,   0);
        check({tag, "_resp_valid"},  resp_valid,  0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_alu_a"},       alu_a,       0);
        check({tag, "_alu_b"},       alu_b,       0);
        check({tag, "_alu_op"},      alu_op,      0);
        check({tag, "_resp_result"}, resp_result, 0);
        check({tag, "_resp_flags"},  resp_flags,  0);
    endtask

    // One complete operation. Called at a falling edge with the DUT in IDLE
    // and at least one request valid; returns at a falling edge in IDLE.
    // drop  : winner withdraws req_valid after its handshake
    // hold  : cycles resp_ready[winner] is held low in RESP
    // raise : all other users raise req_valid while the op is in flight
    task automatic serve(input bit drop, input int hold, input bit raise);
        int          w;
        logic [3:0]  oh;
        logic [34:0] e;
        #1;
        w = model_winner();
        if (w < 0) begin
            check("model_no_request", 1, 0);
            w = 0;
        end
        oh = 4'b0001 << w;
        e  = alu_ref(ua[w], ub[w], uop[w]);
        last_rdy = req_ready;
        check("idle_req_ready", req_ready, oh);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
        if (drop)  req_valid[w] = 1'b0;
        if (raise) req_valid = 4'hF;
        @(negedge clk);
        check("exec_busy", busy, 1);
        check("exec_req_ready", req_ready, 0);
        check("exec_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        resp_ready = ~oh;
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            if (i == 0) begin
                last_res   = resp_result;
                last_flags = resp_flags;
            end
            check("resp_valid", resp_valid, oh);
            check("resp_result", resp_result, e[31:0]);
            check("resp_flags", resp_flags, e[34:32]);
            check("resp_req_ready", req_ready, 0);
            check("resp_busy", busy, 1);
            if (i == hold) resp_ready = oh;
        end
        @(posedge clk); #1;
        resp_ready = 4'b0000;
        ptr_m = (w + 1) % 4;
        @(negedge clk);
        check("done_resp_valid", resp_valid, 0);
        check("done_busy", busy, 0);
    endtask

    initial begin
        resetn     = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        ptr_m      = 0;
        for (int u = 0; u < 4; u++) begin
            ua[u] = '0; ub[u] = '0; uop[u] = '0;
        end

        // ---------------- reset state ----------------
        #2;
        req_valid[0] = 1'b1;
        #10;
        check_all_zero("reset");
`ifdef ALU_ARB_STATS_EN
        check("reset_grant_cnt", grant_cnt, 0);
`endif
        @(negedge clk);
        req_valid = '0;
        resetn    = 1'b1;

        // ---------------- fairness: all four valid ----------------
        @(negedge clk);
        for (int u = 0; u < 4; u++) set_user(u, 32'd100 * (u + 1), 32'd7 + u, OP_ADD);
        for (int k = 0; k < 5; k++) begin
            serve(1'b0, 0, 1'b0);
            check("rr_order", last_rdy, 4'b0001 << (k % 4));
            check("rr_own_sum", last_res, 32'd100 * ((k % 4) + 1) + 32'd7 + (k % 4));
        end
        req_valid = '0;

        // ---------------- directed ALU cases ----------------
        @(negedge clk);
        set_user(0, 32'd5, 32'd7, OP_ADD);
        serve(1'b1, 0, 1'b0);
        check("u0_add_ready", last_rdy, 4'b0001);
        check("u0_add_res", last_res, 32'd12);
        check("u0_add_flags", last_flags, 3'b000);

        set_user(2, 32'd3, 32'd5, OP_SUB);
        serve(1'b1, 0, 1'b0);
        check("u2_sub_res", last_res, 32'hFFFF_FFFE);
        check("u2_sub_flags", last_flags, 3'b010);

        set_user(2, 32'd3, 32'd5, OP_SLT);
        serve(1'b1, 1, 1'b0);
        check("u2_slt_res", last_res, 32'd1);

        set_user(1, 32'h7FFF_FFFF, 32'd1, OP_ADD);
        serve(1'b1, 0, 1'b0);
        check("u1_add_ovf_res", last_res, 32'h8000_0000);
        check("u1_add_ovf_flags", last_flags, 3'b100);

        set_user(1, 32'd9, 32'd9, OP_SUB);
        serve(1'b1, 0, 1'b0);
        check("u1_sub_zero_res", last_res, 32'd0);
        check("u1_sub_zero_flags", last_flags, 3'b001);

        set_user(0, 32'd5, 32'd5, 3'b011);
        serve(1'b1, 0, 1'b0);
        check("undef_op_res", last_res, 32'd0);
        check("undef_op_flags", last_flags, 3'b001);

        set_user(0, 32'hF0F0_1234, 32'h0FF0_FF00, OP_AND);
        serve(1'b1, 0, 1'b0);
        check("and_res", last_res, 32'h00F0_1200);

        // ---------------- backpressure with others waiting ----------------
        set_user(3, 32'd100, 32'd23, OP_ADD);
        serve(1'b1, 5, 1'b1);
        check("u3_hold_res", last_res, 32'd123);
        req_valid = '0;

        // ---------------- randomized traffic ----------------
        for (int it = 0; it < 24; it++) begin
            for (int u = 0; u < 4; u++) begin
                if (!req_valid[u] && ($urandom_range(0, 1) == 1)) begin
                    logic [31:0] ra;
                    logic [31:0] rb;
                    ra = $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    set_user(u, ra, rb, 3'($urandom_range(0, 7)));
                end
            end
            if (req_valid == 4'b0000) set_user(int'($urandom_range(0, 3)), $urandom, $urandom, OP_OR);
            serve(1'b1, int'($urandom_range(0, 2)), 1'b0);
        end
        req_valid = '0;

        // ---------------- reset while in EXEC ----------------
        @(negedge clk);
        set_user(0, 32'd11, 32'd22, OP_ADD);
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
`ifdef ALU_ARB_STATS_EN
        check("midreset_grant_cnt", grant_cnt, 0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        ptr_m  = 0;
        serve(1'b1, 0, 1'b0);
        check("post_reset_ready", last_rdy, 4'b0001);
        check("post_reset_res", last_res, 32'd33);
`ifdef ALU_ARB_STATS_EN
        check("post_reset_cnt_u0", grant_cnt[15:0], 16'd1);
        check("post_reset_cnt_others", grant_cnt[63:16], 48'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
